// File: rtl/spi_package_tx.sv
// spi_package_tx: drains one ping-pong FIFO package byte by byte and shifts it out as SPI mode 0, MSB first.
// Optional 2-byte header (0xA5, pkg_seq) in front of the payload when PKG_HEADER_EN is defined.
// Latency: 3 rd_clk from package_ready rise to spi_cs_n fall; per byte 16*CLK_DIV SPI cycles plus FETCH/WAIT.
// Flow: one rd_en pulse per byte; early package_ready edges are dropped and flagged in overrun.
module spi_package_tx #(
   parameter int DATA_WIDTH    = 8,
   parameter int PACKAGE_SIZE  = 38912,
   parameter int CLK_DIV       = 4,
   parameter int VALID_TIMEOUT = 16
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  package_ready,
   output logic                  rd_en,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] dout,
   output logic                  spi_sclk,
   output logic                  spi_cs_n,
   output logic                  spi_mosi,
   output logic                  busy,
   output logic [7:0]            pkg_seq,
   output logic                  overrun,
   output logic                  timeout_err
);

   localparam int                WAIT_W    = (VALID_TIMEOUT > 1) ? $clog2(VALID_TIMEOUT) : 1;
   localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [8:0]        GAP_LAST  = 9'(2 * CLK_DIV - 1);
   localparam logic [15:0]       BYTE_LAST = 16'(PACKAGE_SIZE - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(VALID_TIMEOUT - 1);

`ifdef PKG_HEADER_EN
   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_FETCH, S_WAIT, S_SHIFT, S_GAP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_GAP
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [2:0]        sync_q;             // [0],[1]: synchronizer, [2]: edge-detect history
   logic [7:0]        sh_q, sh_d;         // shift register, MSB drives spi_mosi
   logic              sclk_q, sclk_d;
   logic [7:0]        div_q, div_d;       // cycles spent in the current SCLK half-period
   logic [2:0]        bit_q, bit_d;       // bits left in the current byte after this one
   logic [15:0]       byte_q, byte_d;     // payload byte index 0..PACKAGE_SIZE-1
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [8:0]        gap_q, gap_d;
   logic [7:0]        seq_q, seq_d;
   logic              ovr_q, ovr_d;
   logic              tmo_q, tmo_d;
   logic              rd_en_q, rd_en_d;
   logic              cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
`ifdef PKG_HEADER_EN
   logic              hdr_q, hdr_d;       // 0: sending magic byte, 1: sending sequence byte
`endif

   logic              start;
   logic              shifting;
   logic              byte_end;
   logic              load_en;
   logic [7:0]        load_val;
   logic              gap_en;

   assign start = sync_q[1] & ~sync_q[2];

`ifdef PKG_HEADER_EN
   assign shifting = (state_q == S_SHIFT) || (state_q == S_HEADER);
`else
   assign shifting = (state_q == S_SHIFT);
`endif

   // last SCLK high half of bit 0: the byte is complete on this edge
   assign byte_end = shifting && sclk_q && (div_q == DIV_LAST) && (bit_q == 3'd0);

   // next-state, bit engine and package bookkeeping
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      sclk_d   = sclk_q;
      div_d    = div_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      wait_d   = wait_q;
      gap_d    = gap_q;
      seq_d    = seq_q;
      ovr_d    = ovr_q;
      tmo_d    = tmo_q;
`ifdef PKG_HEADER_EN
      hdr_d    = hdr_q;
`endif
      load_en  = 1'b0;
      load_val = 8'h00;
      gap_en   = 1'b0;

      // a new package can only be accepted from IDLE; anything else is lost
      if (start && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      // SCLK generator: low half then high half per bit, data moves on the falling edge
      if (shifting) begin
         if (div_q == DIV_LAST) begin
            div_d = 8'd0;
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else begin
               sclk_d = 1'b0;
               if (bit_q != 3'd0) begin
                  bit_d = bit_q - 3'd1;
                  sh_d  = {sh_q[6:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               byte_d = 16'd0;
`ifdef PKG_HEADER_EN
               hdr_d    = 1'b0;
               load_en  = 1'b1;
               load_val = HDR_MAGIC;
               state_d  = S_HEADER;
`else
               state_d  = S_FETCH;
`endif
            end
         end
`ifdef PKG_HEADER_EN
         S_HEADER: begin
            if (byte_end) begin
               if (!hdr_q) begin
                  hdr_d    = 1'b1;
                  load_en  = 1'b1;
                  load_val = seq_q;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
`endif
         S_FETCH: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (valid) begin
               load_en  = 1'b1;
               load_val = dout;
               state_d  = S_SHIFT;
            end else if (wait_q == WAIT_LAST) begin
               tmo_d  = 1'b1;
               gap_en = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (byte_end) begin
               if (byte_q == BYTE_LAST) begin
                  gap_en = 1'b1;
               end else begin
                  byte_d  = byte_q + 16'd1;
                  state_d = S_FETCH;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 9'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // start a fresh byte with SCLK low for a full half-period
      if (load_en) begin
         sh_d   = load_val;
         sclk_d = 1'b0;
         div_d  = 8'd0;
         bit_d  = 3'd7;
      end

      // both normal completion and timeout abort close the package the same way
      if (gap_en) begin
         state_d = S_GAP;
         gap_d   = 9'd0;
         seq_d   = seq_q + 8'd1;
         sh_d    = 8'h00;
      end

      // registered copies of state decodes so the pins are glitch-free
      rd_en_d = (state_d == S_FETCH);
      cs_n_d  = (state_d == S_IDLE) || (state_d == S_GAP);
      busy_d  = (state_d != S_IDLE);
   end

   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sync_q  <= 3'b000;
         sh_q    <= 8'h00;
         sclk_q  <= 1'b0;
         div_q   <= 8'd0;
         bit_q   <= 3'd0;
         byte_q  <= 16'd0;
         wait_q  <= '0;
         gap_q   <= 9'd0;
         seq_q   <= 8'd0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         rd_en_q <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
`ifdef PKG_HEADER_EN
         hdr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[1:0], package_ready};
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         wait_q  <= wait_d;
         gap_q   <= gap_d;
         seq_q   <= seq_d;
         ovr_q   <= ovr_d;
         tmo_q   <= tmo_d;
         rd_en_q <= rd_en_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
`ifdef PKG_HEADER_EN
         hdr_q   <= hdr_d;
`endif
      end
   end

   assign rd_en       = rd_en_q;
   assign spi_sclk    = sclk_q;
   assign spi_cs_n    = cs_n_q;
   assign spi_mosi    = sh_q[7];
   assign busy        = busy_q;
   assign pkg_seq     = seq_q;
   assign overrun     = ovr_q;
   assign timeout_err = tmo_q;

endmodule

// File: doc/spi_package_tx.md
SPI_PACKAGE_TX -- requirements
Module: spi_package_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, FIFO byte width; only 8 is supported.
REQ-002 Parameter PACKAGE_SIZE, default 38912, payload bytes per package; legal range 1..65535.
REQ-003 Parameter CLK_DIV, default 4, rd_clk cycles per SCLK half-period; legal range 1..255.
REQ-004 Parameter VALID_TIMEOUT, default 16, rd_clk cycles to wait for valid after rd_en.
REQ-005 rd_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 package_ready  in  1  ping-pong FIFO package-complete flag, from the wr_clk domain.
REQ-008 rd_en  out  1  one-cycle read request to the FIFO.
REQ-009 valid  in  1  FIFO read data valid.
REQ-010 dout  in  8  FIFO read data, sampled when valid=1.
REQ-011 spi_sclk  out  1  SPI clock, mode 0 (idle low).
REQ-012 spi_cs_n  out  1  chip select, low for the whole package.
REQ-013 spi_mosi  out  1  serial data, MSB first.
REQ-014 busy  out  1  high from package start until return to IDLE.
REQ-015 pkg_seq  out  8  package sequence number.
REQ-016 overrun  out  1  sticky; package_ready edge seen while busy.
REQ-017 timeout_err  out  1  sticky; valid missing within VALID_TIMEOUT.

Function
REQ-018 package_ready shall pass a 2-flop synchronizer; start event = synchronized rising edge; the source holds the flag for at least 2 rd_clk cycles.
REQ-019 FSM states: IDLE, HEADER, FETCH, WAIT, SHIFT, GAP.
REQ-020 Transitions: IDLE->HEADER on a start event (->FETCH without header); HEADER->FETCH after the last header byte; FETCH->WAIT always; WAIT->SHIFT on valid; SHIFT->FETCH after bit 0 when bytes remain; SHIFT->GAP after bit 0 of byte PACKAGE_SIZE-1; GAP->IDLE after 2*CLK_DIV cycles.
REQ-021 rd_en shall be 1 for exactly one cycle in FETCH, exactly PACKAGE_SIZE times per package.
REQ-022 In WAIT, dout shall be captured on the first valid=1 cycle; valid at any other time shall be ignored.
REQ-023 If WAIT lasts VALID_TIMEOUT cycles without valid, the block shall set timeout_err, enter GAP, and abort the package; pkg_seq is still incremented.
REQ-024 Start events arriving in any state other than IDLE shall set overrun and be dropped; they are not queued.
REQ-025 SPI timing: spi_cs_n falls on entry to HEADER/FETCH; spi_mosi changes only while spi_sclk is low; each bit is CLK_DIV cycles low then CLK_DIV cycles high; spi_sclk stays low between bytes.
REQ-026 The byte counter shall be 16-bit and count 0..PACKAGE_SIZE-1 without wrap.
REQ-027 pkg_seq shall increment by 1 on GAP entry and wrap 255->0.
REQ-028 spi_cs_n shall rise on GAP entry and stay high for at least 2*CLK_DIV cycles.

Reset
REQ-029 With rst_n=0 at a clock edge: FSM=IDLE, rd_en=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0, busy=0, pkg_seq=0, overrun=0, timeout_err=0, synchronizer and counters cleared.
REQ-030 Reset during a package shall abort it immediately with no further rd_en pulses.

Configuration
REQ-031 When PKG_HEADER_EN is defined, each package shall start with 2 header bytes, 0xA5 then pkg_seq, before the payload.
REQ-032 When PKG_HEADER_EN is undefined, there is no HEADER state and the payload starts directly after spi_cs_n falls.

Verification
REQ-033 PACKAGE_SIZE=4, CLK_DIV=2, header on; FIFO returns 0x11,0x22,0x33,0x44 -> MOSI bytes A5,00,11,22,33,44; 48 SCLK rising edges; 4 rd_en pulses; pkg_seq=1.
REQ-034 Header off, same stimulus -> MOSI bytes 11,22,33,44; 32 SCLK edges; spi_cs_n high for at least 4 cycles afterwards.
REQ-035 Second package_ready edge mid-package -> overrun=1; current package completes unchanged; no second package.
REQ-036 valid withheld after the 2nd rd_en with VALID_TIMEOUT=16 -> timeout_err=1 after 16 cycles; spi_cs_n rises; busy falls.
REQ-037 256 packages -> pkg_seq wraps to 0; header byte 2 of the 257th package is 0x00.
REQ-038 rst_n=0 during SHIFT -> next cycle spi_cs_n=1, spi_sclk=0, busy=0, no rd_en.
